// File: rtl/round_sequencer.sv
// round_sequencer: game-round FSM that generates, shows and checks a random button pattern
module round_sequencer #(
  parameter int          SHOW_TICKS    = 25_000_000,
  parameter int          GAP_TICKS     = 12_500_000,
  parameter int          TIMEOUT_TICKS = 250_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] difficulty,
  input  logic       press_valid,
  input  logic [2:0] press_idx,
  output logic       show_valid,
  output logic [2:0] show_idx,
  output logic       capture_en,
  output logic       trim_clear,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [4:0] progress,
  output logic [4:0] seq_len
);
  typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_GAP, WAIT_IN, PASS, FAIL} state_t;
  localparam logic [27:0] SHOW_END = 28'(SHOW_TICKS - 1);
  localparam logic [27:0] GAP_END  = 28'(GAP_TICKS - 1);
  localparam logic [27:0] TO_END   = 28'(TIMEOUT_TICKS - 1);
  state_t      state, state_d;
  logic [15:0] lfsr, lfsr_d, lfsr_step;
  logic [27:0] tick, tick_d;
  logic [4:0]  k, k_d, k_inc, progress_d, seq_len_d;
  logic [2:0]  pattern [16];
  logic        hit;
  logic        show_valid_d, capture_en_d, trim_clear_d, busy_d, pass_d, fail_d;
  logic [2:0]  show_idx_d;
  assign lfsr_step = lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
  assign k_inc     = (k == 5'd16) ? k : k + 5'd1;
  assign hit       = press_idx == pattern[k[3:0]];
  // next state and datapath values
  always_comb begin
    state_d    = state;
    lfsr_d     = lfsr;
    tick_d     = tick + 28'd1;
    k_d        = k;
    progress_d = progress;
    seq_len_d  = seq_len;
    case (state)
      IDLE, PASS, FAIL: begin
        lfsr_d = lfsr_step;
        if (start) begin
          seq_len_d  = {1'b0, difficulty, 2'b00} + 5'd4;
          progress_d = 5'd0;
          k_d        = 5'd0;
          state_d    = GEN;
        end
      end
      GEN: begin
        lfsr_d  = lfsr_step;
        k_d     = (k_inc == seq_len) ? 5'd0 : k_inc;
        tick_d  = 28'd0;
        state_d = (k_inc == seq_len) ? SHOW_ON : GEN;
      end
      SHOW_ON: if (tick == SHOW_END) begin
        tick_d  = 28'd0;
        state_d = SHOW_GAP;
      end
      SHOW_GAP: if (tick == GAP_END) begin
        tick_d  = 28'd0;
        k_d     = (k_inc == seq_len) ? 5'd0 : k_inc;
        state_d = (k_inc == seq_len) ? WAIT_IN : SHOW_ON;
      end
      WAIT_IN: begin
        if (press_valid && hit) begin
          k_d        = k_inc;
          progress_d = (progress == 5'd16) ? progress : progress + 5'd1;
          tick_d     = 28'd0;
          state_d    = (k_inc == seq_len) ? PASS : WAIT_IN;
        end else if (press_valid || tick == TO_END) begin
          state_d = FAIL;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // registered outputs are derived from the upcoming state so they track it exactly
  always_comb begin
    show_valid_d = state_d == SHOW_ON;
    show_idx_d   = show_valid_d ? pattern[k_d[3:0]] : 3'd0;
    capture_en_d = state_d == WAIT_IN;
    trim_clear_d = state == SHOW_GAP && state_d == WAIT_IN;
    busy_d       = state_d inside {GEN, SHOW_ON, SHOW_GAP, WAIT_IN};
    pass_d       = state_d == PASS;
    fail_d       = state_d == FAIL;
  end
  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      tick       <= 28'd0;
      k          <= 5'd0;
      progress   <= 5'd0;
      seq_len    <= 5'd0;
      show_valid <= 1'b0;
      show_idx   <= 3'd0;
      capture_en <= 1'b0;
      trim_clear <= 1'b0;
      busy       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_d;
      lfsr       <= lfsr_d;
      tick       <= tick_d;
      k          <= k_d;
      progress   <= progress_d;
      seq_len    <= seq_len_d;
      show_valid <= show_valid_d;
      show_idx   <= show_idx_d;
      capture_en <= capture_en_d;
      trim_clear <= trim_clear_d;
      busy       <= busy_d;
      pass       <= pass_d;
      fail       <= fail_d;
    end
  end
  // pattern store, filled one element per GEN cycle
  always_ff @(posedge clk) begin
    if (state == GEN) pattern[k[3:0]] <= lfsr[2:0];
  end
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed and table-driven checks of round_sequencer with short tick parameters
module tb_round_sequencer;
  logic       clk = 0, rst = 0, start = 0, press_valid = 0;
  logic [1:0] difficulty = 0;
  logic [2:0] press_idx = 0;
  logic       show_valid, capture_en, trim_clear, busy, pass, fail;
  logic [2:0] show_idx;
  logic [4:0] progress, seq_len;
  int         n_chk = 0, n_fail = 0;
  logic [2:0] rec [16];
  logic [2:0] exp_pat [4];
  logic [15:0] m;
  typedef struct {
    logic [1:0] diff;
    int         len;
    int         fail_at;
    int         exp_prog;
    bit         exp_pass;
    bit         exp_fail;
  } vec_t;
  vec_t tbl [4];

  round_sequencer #(.SHOW_TICKS(4), .GAP_TICKS(2), .TIMEOUT_TICKS(20)) dut (
    .clk(clk), .rst(rst), .start(start), .difficulty(difficulty),
    .press_valid(press_valid), .press_idx(press_idx),
    .show_valid(show_valid), .show_idx(show_idx), .capture_en(capture_en),
    .trim_clear(trim_clear), .busy(busy), .pass(pass), .fail(fail),
    .progress(progress), .seq_len(seq_len)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? (v >> 1) ^ 16'hB400 : v >> 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_show_valid"}, show_valid, 0);
    chk({name, "_show_idx"}, show_idx, 0);
    chk({name, "_capture_en"}, capture_en, 0);
    chk({name, "_trim_clear"}, trim_clear, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_pass"}, pass, 0);
    chk({name, "_fail"}, fail, 0);
    chk({name, "_progress"}, progress, 0);
    chk({name, "_seq_len"}, seq_len, 0);
  endtask

  task automatic start_round(input logic [1:0] d);
    difficulty = d;
    start = 1;
    cyc();
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_len", seq_len, 4 * (d + 1));
    chk("start_pass", pass, 0);
    chk("start_fail", fail, 0);
    chk("start_prog", progress, 0);
  endtask

  // walks GEN and the show phase, records the shown pattern; poke injects ignored press/start
  task automatic run_show(input int len, input bit poke);
    for (int i = 1; i < len; i++) begin
      cyc();
      chk("gen_quiet", show_valid, 0);
    end
    for (int j = 0; j < len * 6; j++) begin
      if (poke) begin
        press_valid = (j == 1 || j == 2);
        press_idx = show_idx;
        start = (j == 5);
        difficulty = 2'd3;
      end
      cyc();
      chk("show_valid", show_valid, (j % 6) < 4);
      chk("show_busy", busy, 1);
      if (j % 6 == 0) rec[j / 6] = show_idx;
      else if (j % 6 < 4) chk("show_idx", show_idx, rec[j / 6]);
    end
    press_valid = 0;
    start = 0;
    cyc();
    chk("trim_set", trim_clear, 1);
    chk("cap_en", capture_en, 1);
    cyc();
    chk("trim_pulse", trim_clear, 0);
  endtask

  task automatic press(input logic [2:0] idx);
    press_valid = 1;
    press_idx = idx;
    cyc();
    press_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd0, 4, 4, 4, 1'b1, 1'b0};
    tbl[1] = '{2'd1, 8, 0, 0, 1'b0, 1'b1};
    tbl[2] = '{2'd2, 12, 7, 7, 1'b0, 1'b1};
    tbl[3] = '{2'd3, 16, 16, 16, 1'b1, 1'b0};
    m = 16'hACE1;
    repeat (3) m = lstep(m);
    for (int j = 0; j < 4; j++) begin
      exp_pat[j] = m[2:0];
      m = lstep(m);
    end
    // 1: reset, short round, model-predicted pattern
    repeat (3) cyc();
    chk_zero("reset");
    rst = 1;
    cyc();
    cyc();
    start_round(0);
    run_show(4, 0);
    for (int j = 0; j < 4; j++) chk("pattern_model", rec[j], exp_pat[j]);
    // 2: correct replay
    for (int j = 0; j < 4; j++) begin
      press(rec[j]);
      chk("replay_prog", progress, j + 1);
      chk("replay_pass", pass, j == 3);
      if (j < 3) begin cyc(); cyc(); end
    end
    chk("pass_cap", capture_en, 0);
    chk("pass_busy", busy, 0);
    chk("pass_fail", fail, 0);
    // 3: wrong third press
    start_round(3);
    run_show(16, 0);
    press(rec[0]); cyc(); cyc();
    press(rec[1]); cyc(); cyc();
    press(rec[2] ^ 3'b001);
    chk("wrong_fail", fail, 1);
    chk("wrong_prog", progress, 2);
    chk("wrong_pass", pass, 0);
    chk("wrong_cap", capture_en, 0);
    // 4a: timeout exactly 20 cycles after the last accepted press
    start_round(0);
    run_show(4, 0);
    press(rec[0]);
    for (int i = 1; i < 20; i++) begin
      cyc();
      chk("no_timeout", fail, 0);
    end
    cyc();
    chk("timeout_fail", fail, 1);
    chk("timeout_prog", progress, 1);
    // 4b: press on the expiry cycle wins over the timeout
    start_round(0);
    run_show(4, 0);
    press(rec[0]);
    repeat (19) cyc();
    press(rec[1]);
    chk("collide_fail", fail, 0);
    chk("collide_prog", progress, 2);
    press(rec[2]);
    press(rec[3]);
    chk("collide_pass", pass, 1);
    // 5: start from PASS, presses during SHOW_ON and start during SHOW_GAP ignored
    start_round(1);
    run_show(8, 1);
    chk("ign_len", seq_len, 8);
    chk("ign_prog", progress, 0);
    // 6: reset in WAIT_IN, then a normal round with the reset seed
    press(rec[0]);
    chk("pre_rst_prog", progress, 1);
    rst = 0;
    cyc();
    chk_zero("midrst");
    rst = 1;
    cyc();
    cyc();
    start_round(0);
    run_show(4, 0);
    for (int j = 0; j < 4; j++) chk("reseed_pattern", rec[j], exp_pat[j]);
    for (int j = 0; j < 4; j++) press(rec[j]);
    chk("reseed_pass", pass, 1);
    // table: every difficulty, ending in pass or a wrong press
    foreach (tbl[t]) begin
      start_round(tbl[t].diff);
      run_show(tbl[t].len, 0);
      for (int j = 0; j <= tbl[t].fail_at && j < tbl[t].len; j++)
        press(j == tbl[t].fail_at ? rec[j] ^ 3'b100 : rec[j]);
      chk("tbl_prog", progress, tbl[t].exp_prog);
      chk("tbl_pass", pass, tbl[t].exp_pass);
      chk("tbl_fail", fail, tbl[t].exp_fail);
      chk("tbl_busy", busy, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-round controller that sequences the button-capture datapath.
- Generates a pseudo-random target pattern of 3-bit button indices. Length is set by the difficulty level.
- Plays the pattern out to the display/LED logic, then enables and clears the capture block.
- Checks each captured press against the target and reports pass or fail.

Parameters:
SHOW_TICKS, 25_000_000, cycles each pattern element is shown (show_valid high)
GAP_TICKS, 12_500_000, blank cycles between shown elements
TIMEOUT_TICKS, 250_000_000, max cycles allowed between accepted presses in the input phase
LFSR_SEED, 16'hACE1, reset value of the pattern LFSR (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
start  in  1  one-cycle pulse; begins a round
difficulty  in  2  level 0..3 -> pattern length 4,8,12,16
press_valid  in  1  one-cycle pulse from the capture block: a new press is available
press_idx  in  3  index of the button pressed (0..7), valid with press_valid
show_valid  out  1  high while a pattern element is displayed
show_idx  out  3  element being displayed
capture_en  out  1  enable to the capture block
trim_clear  out  1  one-cycle pulse; clears the capture block's stored presses
busy  out  1  high in every state except IDLE/PASS/FAIL
pass  out  1  sticky round-success flag
fail  out  1  sticky round-failure flag
progress  out  5  number of correct presses so far this round
seq_len  out  5  latched pattern length (4..16)

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; all outputs 0.
  - LFSR=LFSR_SEED; pattern memory contents don't-care.
  - Reset mid-round aborts immediately; no pass/fail is reported.
- LFSR: 16-bit Galois, right shift, taps mask 16'hB400.
  - Steps every cycle in IDLE/PASS/FAIL, so the seed depends on when start arrives.
  - Steps once per stored element in GEN; frozen otherwise.
- Pattern store: 16 x 3-bit registers.
- IDLE/PASS/FAIL + start:
  - Latch seq_len = 4*(difficulty+1).
  - Clear pass, fail and progress; element counter k=0; go to GEN.
  - start in any other state is ignored.
- GEN, one cycle per element:
  - pattern[k] = LFSR[2:0]; k++.
  - After seq_len cycles: k=0, go to SHOW_ON.
- SHOW_ON:
  - show_valid=1, show_idx=pattern[k] for exactly SHOW_TICKS cycles, then go to SHOW_GAP.
- SHOW_GAP:
  - show_valid=0 for GAP_TICKS cycles, then k++.
  - If k==seq_len: go to WAIT_IN, with trim_clear=1 on the transition cycle, and k=0.
  - Otherwise return to SHOW_ON.
  - Total show phase = seq_len*(SHOW_TICKS+GAP_TICKS) cycles.
- WAIT_IN:
  - capture_en=1; timeout counter starts at 0.
  - press_valid with press_idx==pattern[k]:
    - k++, progress++, timeout counter cleared.
    - If the new k==seq_len, go to PASS next cycle.
  - press_valid with mismatch: go to FAIL next cycle; progress holds.
  - Timeout counter reaching TIMEOUT_TICKS with no press: go to FAIL.
  - press_valid in the same cycle as timeout expiry: the press is evaluated and the timeout is ignored.
- press_valid outside WAIT_IN: ignored entirely (no progress change, no fail).
- PASS: pass=1, capture_en=0. Held until start or reset.
- FAIL: fail=1, capture_en=0. Held until start or reset.
- pass and fail are never high together.
- busy=1 in GEN, SHOW_ON, SHOW_GAP, WAIT_IN.
- Output registering: all outputs are registered; they change one cycle after the causing edge.
- Counters: tick counter 28 bits; k and progress 5 bits, saturating at 16.

Test Plan (SHOW_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20):
1. Reset hold 3 cycles, then start with difficulty=0:
   - seq_len=4; busy rises; GEN lasts 4 cycles.
   - show_valid shows 4 pulses, each 4 cycles high and 2 cycles low (24 cycles).
   - trim_clear pulses once; capture_en=1.
2. Correct replay: after case 1, feed the 4 recorded show_idx values as press_valid pulses 3 cycles apart.
   - progress steps 1,2,3,4.
   - pass=1 the cycle after the 4th press; capture_en=0; busy=0.
3. Wrong press: difficulty=3 (seq_len=16), correct first 2 presses, third press = pattern[2] XOR 3'b001.
   - fail=1 next cycle; progress stays 2; pass=0.
4. Timeout and collision:
   - One correct press, then silence: fail=1 exactly 20 cycles after that press.
   - Rerun with a correct press landing on the expiry cycle: no fail, progress increments.
5. Ignored inputs:
   - press_valid pulses during SHOW_ON: progress stays 0.
   - start during SHOW_GAP: no restart; seq_len unchanged.
   - In PASS, start with difficulty=1: new round with seq_len=8; pass clears.
6. Reset mid-round: rst=0 for 1 cycle during WAIT_IN.
   - All outputs 0, state IDLE, LFSR=16'hACE1.
   - A following start produces a normal round.
